sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM macro (sram_sp style: 1R-or-1W per cycle, read data one cycle after ren) between a write requester (write scanner path) and a read requester (read scanner / buffet lookup path) inside a fiber-access tile.
- Burst-limited round-robin FSM grants the port.
- A 2-entry credit-controlled response FIFO lets the read consumer back-pressure without losing SRAM data.

---
 rtl/sram_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Burst-limited round-robin arbiter sharing one single-port SRAM between a write and a read requester,
// with a 2-entry credit-controlled read response FIFO. Optional grant/stall counters: SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 9,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              clk_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              wen_to_mem,
  output logic              ren_to_mem,
  input  logic [DATA_W-1:0] data_from_mem
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]       wr_grant_count,
  output logic [31:0]       rd_grant_count,
  output logic [31:0]       rd_stall_count
`endif
);

  // Handshakes: a request transfers on a cycle where valid and ready are both high at the
  // clock edge; ready never depends on anything but current state and this cycle's requests.
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_below;
  logic             last_rd;
  logic             inflight;

  logic [DATA_W-1:0] fifo_mem [0:1];
  logic              fifo_wptr;
  logic              fifo_rptr;
  logic [1:0]        occ;
  logic [2:0]        credit_used;

  logic want_wr;
  logic want_rd;
  logic arb_wr;
  logic arb_rd;
  logic grant_wr;
  logic grant_rd;
  logic push;
  logic pop;

  // A read may only start if both the FIFO slot and any data still in the SRAM pipe fit.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign want_rd     = rd_valid & (credit_used < 3'd2);
  assign want_wr     = wr_valid;

  assign cnt_below = (cnt < CNT_MAX);
  assign cnt_inc   = cnt_below ? cnt + CNT_ONE : cnt;

  always_comb begin
    arb_wr    = 1'b0;
    arb_rd    = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WR: begin
        if (want_wr & (~want_rd | cnt_below)) begin
          arb_wr  = 1'b1;
          cnt_nxt = cnt_inc;
        end else if (want_rd) begin
          arb_rd    = 1'b1;
          state_nxt = ST_RD;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_RD: begin
        if (want_rd & (~want_wr | cnt_below)) begin
          arb_rd  = 1'b1;
          cnt_nxt = cnt_inc;
        end else if (want_wr) begin
          arb_wr    = 1'b1;
          state_nxt = ST_WR;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (want_wr & want_rd) begin
          arb_wr = last_rd;
          arb_rd = ~last_rd;
        end else begin
          arb_wr = want_wr;
          arb_rd = want_rd;
        end
        if (arb_wr) begin
          state_nxt = ST_WR;
          cnt_nxt   = CNT_ONE;
        end else if (arb_rd) begin
          state_nxt = ST_RD;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign grant_wr = arb_wr & clk_en & ~flush;
  assign grant_rd = arb_rd & clk_en & ~flush;

  assign wr_ready    = grant_wr;
  assign rd_ready    = grant_rd;
  assign wen_to_mem  = grant_wr;
  assign ren_to_mem  = grant_rd;
  assign addr_to_mem = flush ? '0 : (grant_rd ? rd_addr : wr_addr);
  assign data_to_mem = flush ? '0 : wr_data;

  assign rd_data_valid = ~flush & (occ != 2'd0);
  assign rd_data       = flush ? '0 : fifo_mem[fifo_rptr];
  assign push          = inflight;
  assign pop           = rd_data_valid & rd_data_ready & clk_en;

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_rd   <= 1'b1;
      inflight  <= 1'b0;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
      occ       <= 2'd0;
    end else if (clk_en) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      inflight <= grant_rd;
      if (grant_wr) begin
        last_rd <= 1'b0;
      end else if (grant_rd) begin
        last_rd <= 1'b1;
      end
      if (push) begin
        fifo_wptr <= ~fifo_wptr;
      end
      if (pop) begin
        fifo_rptr <= ~fifo_rptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (~flush & clk_en & push) begin
      fifo_mem[fifo_wptr] <= data_from_mem;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_grant_count <= '0;
      rd_grant_count <= '0;
      rd_stall_count <= '0;
    end else if (clk_en) begin
      if (grant_wr && (wr_grant_count != '1)) begin
        wr_grant_count <= wr_grant_count + 32'd1;
      end
      if (grant_rd && (rd_grant_count != '1)) begin
        rd_grant_count <= rd_grant_count + 32'd1;
      end
      if (rd_valid && !grant_rd && (rd_stall_count != '1)) begin
        rd_stall_count <= rd_stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a transaction-level
// arbiter model; read responses are checked through an expected-data queue by a separate monitor.
module tb_sram_port_arbiter;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 9;
  localparam int BURST_LEN = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              flush;
  logic              clk_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_data_ready;
  logic [ADDR_W-1:0] addr_to_mem;
  logic [DATA_W-1:0] data_to_mem;
  logic              wen_to_mem;
  logic              ren_to_mem;
  logic [DATA_W-1:0] data_from_mem;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] wr_grant_count;
  logic [31:0] rd_grant_count;
  logic [31:0] rd_stall_count;
`endif

  sram_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .flush(flush), .clk_en(clk_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
    .wen_to_mem(wen_to_mem), .ren_to_mem(ren_to_mem), .data_from_mem(data_from_mem)
`ifdef SRAM_ARB_STATS_EN
    , .wr_grant_count(wr_grant_count), .rd_grant_count(rd_grant_count),
    .rd_stall_count(rd_stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Single-port SRAM: output register holds when not reading.
  logic [DATA_W-1:0] sram [0:DEPTH-1];
  always @(posedge clk) begin
    if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
    if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_mem [0:DEPTH-1];
  int m_ages[$];     // enabled edges since accept, one per read not yet consumed
  int m_owner;       // 0 nobody, 1 writer, 2 reader
  int m_run;         // consecutive grants to m_owner
  bit m_last_rd;
  bit m_gw;
  bit m_gr;
  int stat_w, stat_r, stat_s;
  logic [DATA_W-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT outputs against the model, then advance the model.
  task automatic step();
    bit want_w, want_r, exp_v, own_w, own_r;
    int g;
    @(negedge clk);
    m_gw = 1'b0;
    m_gr = 1'b0;
    if (flush) begin
      check("flush_grants", {wr_ready, rd_ready, wen_to_mem, ren_to_mem}, 64'd0);
      check("flush_addr", addr_to_mem, 64'd0);
      check("flush_wdata", data_to_mem, 64'd0);
      check("flush_rvalid", rd_data_valid, 64'd0);
      check("flush_rdata", rd_data, 64'd0);
      m_owner = 0; m_run = 0; m_last_rd = 1'b1;
      m_ages.delete(); exp_q.delete();
      stat_w = 0; stat_r = 0; stat_s = 0;
    end else begin
      want_w = wr_valid;
      want_r = rd_valid && (m_ages.size() < 2);
      own_w  = (m_owner == 1);
      own_r  = (m_owner == 2);
      if (clk_en) begin
        if (own_w && want_w && (!want_r || m_run < BURST_LEN)) m_gw = 1'b1;
        else if (own_r && want_r && (!want_w || m_run < BURST_LEN)) m_gr = 1'b1;
        else if (own_w) m_gr = want_r;
        else if (own_r) m_gw = want_w;
        else if (want_w && want_r) begin m_gw = m_last_rd; m_gr = !m_last_rd; end
        else begin m_gw = want_w; m_gr = want_r; end
      end
      exp_v = (m_ages.size() > 0) && (m_ages[0] >= 2);
      check("grants", {wr_ready, rd_ready, wen_to_mem, ren_to_mem}, {60'd0, m_gw, m_gr, m_gw, m_gr});
      check("addr_to_mem", addr_to_mem, m_gr ? rd_addr : wr_addr);
      check("data_to_mem", data_to_mem, wr_data);
      check("rd_data_valid", rd_data_valid, exp_v);
      if (clk_en) begin
        if (exp_v && rd_data_ready) void'(m_ages.pop_front());
        foreach (m_ages[i]) m_ages[i]++;
        if (m_gr) begin
          m_ages.push_back(1);
          exp_q.push_back(m_mem[rd_addr]);
        end
        if (m_gw) m_mem[wr_addr] = wr_data;
        if (m_gw) stat_w++;
        if (m_gr) stat_r++;
        if (rd_valid && !m_gr) stat_s++;
        if (m_gw || m_gr) begin
          g = m_gw ? 1 : 2;
          m_run = (g == m_owner) ? m_run + 1 : 1;
          m_owner = g;
          m_last_rd = m_gr;
        end else begin
          m_owner = 0;
          m_run = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!flush && clk_en && rd_data_valid && rd_data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data_unexpected: got %h expected no response at %0t", rd_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", rd_data, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] rq[$];
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]  = '0;
      m_mem[i] = '0;
    end
    data_from_mem = '0;
    flush = 1'b1; clk_en = 1'b1; rd_data_ready = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    step();
    step();
    flush = 1'b0;

    // Writes only, addresses 0..3
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(i);
      wr_data  = 64'h10 + 64'(i);
      step();
    end
    idle(2);

    // Both sides requesting continuously from a fresh reset
    do_flush();
    wr_valid = 1'b1; rd_valid = 1'b1; rd_data_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wr_addr = ADDR_W'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom};
      rd_addr = ADDR_W'($urandom_range(0, 7));
      step();
    end
    idle(4);

    // Read-after-write of the same address
    wr_valid = 1'b1; wr_addr = 9'd5; wr_data = 64'hDEAD;
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5;
    step();
    idle(4);

    // Back-pressured consumer: reads to 1,2,3 held until accepted
    rd_data_ready = 1'b0;
    rq = '{9'd1, 9'd2, 9'd3};
    for (int i = 0; i < 8; i++) begin
      rd_valid = (rq.size() > 0);
      rd_addr  = (rq.size() > 0) ? rq[0] : '0;
      step();
      if (m_gr) void'(rq.pop_front());
    end
    rd_data_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rd_valid = (rq.size() > 0);
      rd_addr  = (rq.size() > 0) ? rq[0] : '0;
      step();
      if (m_gr) void'(rq.pop_front());
    end
    idle(4);

    // Flush while a read is in flight
    rd_valid = 1'b1; rd_addr = 9'd2;
    step();
    rd_valid = 1'b0;
    do_flush();
    idle(3);
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 9'd9; rd_addr = 9'd3; wr_data = 64'h99;
    step();
    idle(4);

    // Clock qualifier low with both requests pending
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 9'd4; rd_addr = 9'd1; wr_data = 64'h44;
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      flush         = ($urandom_range(0, 99) == 0);
      clk_en        = ($urandom_range(0, 9) != 0);
      wr_valid      = $urandom_range(0, 1) == 1;
      rd_valid      = $urandom_range(0, 1) == 1;
      wr_addr       = ADDR_W'($urandom_range(0, 15));
      rd_addr       = ADDR_W'($urandom_range(0, 15));
      wr_data       = {$urandom, $urandom};
      rd_data_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    flush = 1'b0; clk_en = 1'b1; rd_data_ready = 1'b1;
    idle(6);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

`ifdef SRAM_ARB_STATS_EN
    check("wr_grant_count", wr_grant_count, 64'(stat_w));
    check("rd_grant_count", rd_grant_count, 64'(stat_r));
    check("rd_stall_count", rd_stall_count, 64'(stat_s));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
